bram_capture_ctrl: RTL
======================

# bram_capture_ctrl

Capture/readout sequencer for the 6144×9 sample BRAM (13-bit address, valid range 0..6143). It writes incoming 8-bit samples circularly into the BRAM while armed, tags the trigger sample in the parity bit, and stops after a programmable post-trigger count. It then serves pipelined oldest-first reads to the host-side readout logic. It sits between the sampler/trigger front end and the BRAM, and is the BRAM's sole driver.

## Interface
Parameters:
- DEPTH, 6144, BRAM words; addresses wrap DEPTH-1 -> 0
- AW, 13, address width

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ARM  in  1  start capture (pulse); accepted in IDLE or DONE
- ABORT  in  1  return to IDLE from any state; priority over ARM
- POST_COUNT  in  13  samples stored after the trigger sample; sampled at ARM; values >6143 clamp to 6143
- SAMPLE_VALID  in  1  SAMPLE qualifier
- SAMPLE  in  8  sample data
- TRIGGER  in  1  trigger flag, qualified by SAMPLE_VALID
- RD_REQ  in  1  read-next request; one word per cycle
- RD_VALID  out  1  RD_DATA valid
- RD_DATA  out  9  {marker, sample}
- RD_LEFT  out  13  words not yet requested
- BUSY  out  1  state is ARMED or POST
- TRIGGERED  out  1  trigger seen in current capture
- DONE  out  1  state is DONE
- MEM_ADDR  out  13  BRAM address
- MEM_EN  out  1  BRAM enable
- MEM_WE  out  1  BRAM write enable
- MEM_DIN  out  8  BRAM write data
- MEM_DINP  out  1  BRAM parity input; 1 only for the trigger sample
- MEM_DOUT  in  8  BRAM read data
- MEM_DOUTP  in  1  BRAM parity output

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE: no BRAM access. ARM -> ARMED. Clear wr_ptr, wrapped, and TRIGGERED. Latch the clamped POST_COUNT.
- ARMED: each SAMPLE_VALID writes SAMPLE at wr_ptr with MEM_DINP=0.
  - wr_ptr increments mod 6144. On wrap 6143->0, set wrapped.
  - If SAMPLE_VALID and TRIGGER: write that sample with MEM_DINP=1 and set TRIGGERED.
  - Then: if POST_COUNT=0, go to DONE; else load post_left=POST_COUNT and go to POST.
- POST: each SAMPLE_VALID writes the sample (MEM_DINP=0, TRIGGER ignored) and decrements post_left. The write that takes post_left from 1 to 0 moves the state to DONE.
- Entry to DONE sets:
  - rd_len = wrapped ? 6144 : wr_ptr
  - rd_ptr = wrapped ? wr_ptr : 0
  - RD_LEFT = rd_len
- DONE reads:
  - RD_REQ with RD_LEFT>0 issues a read at rd_ptr. rd_ptr increments mod 6144 and RD_LEFT decrements.
  - RD_REQ with RD_LEFT=0 is ignored: no MEM_EN, no RD_VALID.
- DONE, other events: ARM re-arms (goes to ARMED and reinitialises as for IDLE). Samples are ignored in DONE.
- ABORT in any state: go to IDLE. MEM_EN and MEM_WE drop on the next edge. In-flight read data is discarded, so RD_VALID=0 from the next cycle.
- ARM in ARMED or POST is ignored.

## Timing
- All outputs are registered except RD_DATA, which is {MEM_DOUTP, MEM_DOUT} passed through.
- Reset values:
  - State: IDLE.
  - Flags and pointers: all MEM_* outputs, RD_VALID, RD_LEFT, BUSY, TRIGGERED, DONE, wr_ptr, rd_ptr, and post_left are 0.
  - RD_DATA reflects MEM_DOUT.
- Write path: a sample presented at edge n drives MEM_EN=MEM_WE=1 with its address and data during cycle n+1. Full rate, one sample per cycle.
- State flags: DONE, BUSY, and TRIGGERED update at the same edge that registers the terminating or triggering write.
- Read path: RD_REQ at edge n drives MEM_EN=1, MEM_WE=0 during n+1. RD_VALID=1 and RD_DATA are valid during n+2. Latency is 2. Back-to-back requests give one word per cycle.
- Reset behaviour: asserting RESET_N low mid-operation forces all outputs to their reset values immediately, without waiting for CLK.

## Test plan
- Reset: assert RESET_N low mid-capture -> all outputs are 0 and the state is IDLE with no clock edge; ARM after release -> BUSY=1 one cycle later.
- Basic capture (POST_COUNT=10, ARM, samples 0..99 = index value, TRIGGER on sample 40):
  - DONE rises on the edge registering sample 50; samples 51+ are not written.
  - RD_LEFT=51. Reading 51 words returns 0..50, with bit 8 set only on word 40.
- Wrap (POST_COUNT=5, sample i = i mod 256 for i=0..6995, TRIGGER at i=6990):
  - DONE after sample 6995 and RD_LEFT=6144.
  - First word read = 852 mod 256 = 0x54. Marker set only on read index 6138.
- Zero post (POST_COUNT=0, TRIGGER on the first sample 0xA5) -> DONE next edge, RD_LEFT=1, single read returns 0x1A5.
- Read handshake (after the basic-capture run):
  - RD_REQ held high 53 cycles -> exactly 51 RD_VALID pulses, contiguous, starting 2 cycles after the first request.
  - MEM_EN is not asserted for the 2 excess requests, and RD_LEFT ends at 0.
- Abort/re-arm:
  - ABORT during POST -> MEM_WE=0 next cycle, state IDLE, DONE never asserts.
  - ABORT and ARM in the same cycle -> IDLE.
  - ARM in DONE -> BUSY=1, TRIGGERED=0, and the new capture starts at address 0.

Source files
------------

// File: rtl/bram_capture_ctrl.sv
// Capture/readout sequencer for the 6144x9 sample BRAM: circular capture with a
// parity-tagged trigger sample, post-trigger stop, then oldest-first pipelined reads.
module bram_capture_ctrl #(
  parameter int DEPTH  = 6144,
  parameter int AW     = 13,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ARM,
  input  logic              ABORT,
  input  logic [AW-1:0]     POST_COUNT,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic              TRIGGER,
  input  logic              RD_REQ,
  output logic              RD_VALID,
  output logic [DATA_W:0]   RD_DATA,
  output logic [AW-1:0]     RD_LEFT,
  output logic              BUSY,
  output logic              TRIGGERED,
  output logic              DONE,
  output logic [AW-1:0]     MEM_ADDR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_DIN,
  output logic              MEM_DINP,
  input  logic [DATA_W-1:0] MEM_DOUT,
  input  logic              MEM_DOUTP
);

  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL  = AW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE_S} state_t;

  function automatic logic [AW-1:0] sat_post(input logic [AW-1:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  state_t            state, state_nxt;
  logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
  logic              wrapped, wrapped_nxt;
  logic              trig, trig_nxt;
  logic [AW-1:0]     post_cnt, post_cnt_nxt;
  logic [AW-1:0]     post_left, post_left_nxt;
  logic [AW-1:0]     rd_ptr, rd_ptr_nxt;
  logic [AW-1:0]     rd_left, rd_left_nxt;
  logic [AW-1:0]     addr_nxt;
  logic              en_nxt, we_nxt, dinp_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              vld_p0, vld_p0_nxt;
  logic              vld_p1, vld_p1_nxt;
  logic              busy_nxt, done_nxt;
  logic              do_arm, do_wr, do_rd, end_cap;

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wrapped_nxt   = wrapped;
    trig_nxt      = trig;
    post_cnt_nxt  = post_cnt;
    post_left_nxt = post_left;
    rd_ptr_nxt    = rd_ptr;
    rd_left_nxt   = rd_left;
    addr_nxt      = MEM_ADDR;
    en_nxt        = 1'b0;
    we_nxt        = 1'b0;
    din_nxt       = MEM_DIN;
    dinp_nxt      = 1'b0;
    vld_p0_nxt    = 1'b0;
    vld_p1_nxt    = vld_p0;
    do_arm        = 1'b0;
    do_wr         = 1'b0;
    do_rd         = 1'b0;
    end_cap       = 1'b0;

    if (ABORT) begin
      state_nxt   = IDLE;
      rd_left_nxt = '0;
      vld_p1_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE:  do_arm = ARM;
        ARMED: begin
          if (SAMPLE_VALID) begin
            do_wr = 1'b1;
            if (TRIGGER) begin
              dinp_nxt = 1'b1;
              trig_nxt = 1'b1;
              if (post_cnt == '0) begin
                end_cap = 1'b1;
              end else begin
                post_left_nxt = post_cnt;
                state_nxt     = POST;
              end
            end
          end
        end
        POST: begin
          if (SAMPLE_VALID) begin
            do_wr         = 1'b1;
            post_left_nxt = post_left - 1'b1;
            end_cap       = (post_left == AW'(1));
          end
        end
        DONE_S: begin
          do_arm = ARM;
          do_rd  = !ARM && RD_REQ && (rd_left != '0);
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (do_arm) begin
      state_nxt    = ARMED;
      wr_ptr_nxt   = '0;
      wrapped_nxt  = 1'b0;
      trig_nxt     = 1'b0;
      post_cnt_nxt = sat_post(POST_COUNT);
      rd_left_nxt  = '0;
    end

    if (do_wr) begin
      en_nxt     = 1'b1;
      we_nxt     = 1'b1;
      addr_nxt   = wr_ptr;
      din_nxt    = SAMPLE;
      wr_ptr_nxt = inc_wrap(wr_ptr);
      if (wr_ptr == LAST) wrapped_nxt = 1'b1;
    end

    // Readout window is fixed from the pointer state after the terminating write.
    if (end_cap) begin
      state_nxt   = DONE_S;
      rd_left_nxt = wrapped_nxt ? FULL : wr_ptr_nxt;
      rd_ptr_nxt  = wrapped_nxt ? wr_ptr_nxt : '0;
    end

    if (do_rd) begin
      en_nxt      = 1'b1;
      addr_nxt    = rd_ptr;
      rd_ptr_nxt  = inc_wrap(rd_ptr);
      rd_left_nxt = rd_left - 1'b1;
      vld_p0_nxt  = 1'b1;
    end

    busy_nxt = (state_nxt == ARMED) || (state_nxt == POST);
    done_nxt = (state_nxt == DONE_S);
  end

  // Stage p0: command registers (BRAM port, flags); stage p1: read data valid.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      trig      <= 1'b0;
      post_cnt  <= '0;
      post_left <= '0;
      rd_ptr    <= '0;
      rd_left   <= '0;
      MEM_ADDR  <= '0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_DIN   <= '0;
      MEM_DINP  <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wrapped   <= wrapped_nxt;
      trig      <= trig_nxt;
      post_cnt  <= post_cnt_nxt;
      post_left <= post_left_nxt;
      rd_ptr    <= rd_ptr_nxt;
      rd_left   <= rd_left_nxt;
      MEM_ADDR  <= addr_nxt;
      MEM_EN    <= en_nxt;
      MEM_WE    <= we_nxt;
      MEM_DIN   <= din_nxt;
      MEM_DINP  <= dinp_nxt;
      vld_p0    <= vld_p0_nxt;
      vld_p1    <= vld_p1_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
    end
  end

  assign TRIGGERED = trig;
  assign RD_LEFT   = rd_left;
  assign RD_VALID  = vld_p1;
  assign RD_DATA   = {MEM_DOUTP, MEM_DOUT};

endmodule
